// File: rtl/or1200_rf_mp_if.sv
// rtl/or1200_rf_mp_if.sv - pipeline read/write ports and SPR bus of the multi-issue register file
interface or1200_rf_mp_if #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int LANES = 2
);
  logic                supv;
  logic                wb_freeze;
  logic                flushpipe;
  logic [LANES-1:0]    we;
  logic [LANES*AW-1:0] addrw;
  logic [LANES*DW-1:0] dataw;
  logic                id_freeze;
  logic [LANES-1:0]    rda;
  logic [LANES-1:0]    rdb;
  logic [LANES*AW-1:0] addra;
  logic [LANES*AW-1:0] addrb;
  logic [LANES*DW-1:0] dataa;
  logic [LANES*DW-1:0] datab;
  logic                spr_cs;
  logic                spr_write;
  logic [31:0]         spr_addr;
  logic [31:0]         spr_dat_i;
  logic [31:0]         spr_dat_o;
  logic                spr_ack;
  logic                rf_busy;

  modport master (
    output supv, wb_freeze, flushpipe, we, addrw, dataw,
    output id_freeze, rda, rdb, addra, addrb,
    output spr_cs, spr_write, spr_addr, spr_dat_i,
    input  dataa, datab, spr_dat_o, spr_ack, rf_busy
  );

  modport slave (
    input  supv, wb_freeze, flushpipe, we, addrw, dataw,
    input  id_freeze, rda, rdb, addra, addrb,
    input  spr_cs, spr_write, spr_addr, spr_dat_i,
    output dataa, datab, spr_dat_o, spr_ack, rf_busy
  );
endinterface

// File: rtl/or1200_rf_mp.sv
// rtl/or1200_rf_mp.sv - multi-issue OR1200 GPR file with SPR access and post-reset clearing sweep
// Optional write-to-read bypass enabled by defining OR1200_RF_BYPASS_EN.
module or1200_rf_mp #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               rst,
  or1200_rf_mp_if.slave      bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {CLEAR, IDLE, SPR} state_t;

  state_t              state;
  logic [AW-1:0]       clr_cnt;
  logic [DW-1:0]       mem [DEPTH];

  logic [LANES-1:0]    wcommit;
  logic [AW-1:0]       waddr [LANES];
  logic [DW-1:0]       wdata [LANES];
  logic                spr_hit;
  logic                spr_wr;
  logic [AW-1:0]       spr_idx;
  logic [LANES*DW-1:0] rd_a;
  logic [LANES*DW-1:0] rd_b;
  logic [DW-1:0]       rd_spr;
  logic                unused_spr_addr;

  assign unused_spr_addr = ^bus.spr_addr[31:16];

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      waddr[k]   = bus.addrw[k*AW +: AW];
      wdata[k]   = bus.dataw[k*DW +: DW];
      wcommit[k] = (state != CLEAR) && bus.we[k] && !bus.wb_freeze && !bus.flushpipe
                   && (waddr[k] != '0);
    end
  end

  assign spr_idx = bus.spr_addr[AW-1:0];
  assign spr_hit = bus.spr_cs && (bus.spr_addr[15:11] == 5'd0) && bus.spr_addr[10]
                   && (bus.spr_addr[9:AW] == '0);
  assign spr_wr  = (state == SPR) && bus.spr_write && bus.supv && (spr_idx != '0);

  // Later lanes scanned last so the highest committing lane supplies the bypass value.
  function automatic logic [DW-1:0] read_entry(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = (a == '0) ? '0 : mem[a];
`ifdef OR1200_RF_BYPASS_EN
    for (int j = 0; j < LANES; j++)
      if (wcommit[j] && (waddr[j] == a))
        v = wdata[j];
`endif
    return v;
  endfunction

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_a[k*DW +: DW] = read_entry(bus.addra[k*AW +: AW]);
      rd_b[k*DW +: DW] = read_entry(bus.addrb[k*AW +: AW]);
    end
    rd_spr = read_entry(spr_idx);
  end

  // Statement order gives pipeline writes priority over SPR, and higher lanes over lower.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (spr_wr)
        mem[spr_idx] <= bus.spr_dat_i[DW-1:0];
      for (int k = 0; k < LANES; k++)
        if (wcommit[k])
          mem[waddr[k]] <= wdata[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= CLEAR;
      clr_cnt       <= '0;
      bus.rf_busy   <= 1'b1;
      bus.spr_ack   <= 1'b0;
      bus.spr_dat_o <= '0;
      bus.dataa     <= '0;
      bus.datab     <= '0;
    end else begin
      bus.spr_ack <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state       <= IDLE;
            bus.rf_busy <= 1'b0;
          end
        end
        IDLE: begin
          if (spr_hit)
            state <= SPR;
        end
        SPR: begin
          bus.spr_ack <= 1'b1;
          if (!bus.spr_write)
            bus.spr_dat_o <= 32'(rd_spr);
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase

      if ((state != CLEAR) && !bus.id_freeze) begin
        for (int k = 0; k < LANES; k++) begin
          if (bus.rda[k])
            bus.dataa[k*DW +: DW] <= rd_a[k*DW +: DW];
          if (bus.rdb[k])
            bus.datab[k*DW +: DW] <= rd_b[k*DW +: DW];
        end
      end
    end
  end
endmodule
